data8in: RTL and testbench
==========================

# data8in

Byte-to-word deserializer: the receive end of the 8-bit byte stream produced by `data8out`. It accepts one byte per strobed `pclk` edge, most-significant byte first, and assembles `NBYTES` bytes into one wide word. It then presents the word with a one-cycle `ready` pulse. Partial words stalled longer than `GAP` idle cycles are discarded and flagged, so the receiver re-aligns to word boundaries after a dropped byte.

## Interface
Parameters:
- `GAP`, default 4: maximum consecutive idle cycles allowed between bytes of one word; 0 disables the timeout.
- `NBYTES`, default 5: bytes per word, minimum 1; word width is 8*`NBYTES`.

Ports:
- `pclk`, input, 1: sole clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, 8: incoming byte.
- `inputReady`, input, 1: `din` is valid this cycle; sampled every edge.
- `dout`, output, 8*`NBYTES`: last completed word, held until the next word completes.
- `ready`, output, 1: one-cycle pulse, `dout` newly updated.
- `busy`, output, 1: a partial word is held (state COLLECT).
- `error`, output, 1: one-cycle pulse, partial word discarded by timeout.

## Operation
- One clock and one reset: `pclk` with synchronous, active-high `rst`.
- Reset values: `dout`=0, `ready`=0, `busy`=0, `error`=0, byte count=0, idle count=0, state=IDLE.
- States:
  - IDLE: no bytes held.
  - COLLECT: 1..`NBYTES`-1 bytes held.
- Byte order: the first byte of a word lands in `dout[8*NBYTES-1 -: 8]`; the last byte lands in `dout[7:0]`.
- Byte counter width: $clog2(`NBYTES`+1).
- Idle counter width: $clog2(`GAP`+1), saturating.
- IDLE, `inputReady`=1: the byte goes into the shift register with count=1 and the state moves to COLLECT. When `NBYTES`=1 the word completes immediately and the state stays IDLE.
- COLLECT, `inputReady`=1: shift the byte in and increment the count. Clear the idle counter.
  - When the count reaches `NBYTES`: load the assembled word into `dout`, set `ready`=1 for one cycle, reset the count, and return to IDLE.
- COLLECT, `inputReady`=0: increment the idle counter.
  - When it reaches `GAP` (`GAP`>0): discard the partial word, pulse `error`, and return to IDLE.
  - `dout` is untouched on abort.
- IDLE, `inputReady`=0: nothing changes; there is no timeout in IDLE.
- A byte arriving on the edge where the idle counter would reach `GAP` is accepted; the accept wins over the timeout.
- A first byte of the next word on the edge after completion is accepted normally. Back-to-back words need no dead cycle.
- There is no backpressure. The consumer must capture `dout` before the next `ready`; `dout` is stable for at least `NBYTES` cycles after each `ready`.
- `rst` mid-word discards the partial word and forces all reset values on that edge; `inputReady` on that edge is ignored.
- `ready` and `error` are never both 1 in the same cycle.

## Timing
- All outputs are registered.
- Latency: the edge that samples the `NBYTES`-th byte also updates `dout` and raises `ready` in the following cycle. For `NBYTES`=5 with back-to-back bytes on edges 1..5, `ready` is high between edges 5 and 6.
- `busy` rises after the edge accepting the first byte. It falls after the edge completing or aborting the word.
- `error` rises after the `GAP`-th consecutive idle edge in COLLECT.
- Throughput: one byte per cycle sustained; one word per `NBYTES` cycles.

## Structure
- Shared package `data8_pkg`, also used by `data8out`:
  - byte width constant `BYTE_W`=8;
  - state encoding constants `ST_IDLE`, `ST_COLLECT`;
  - a function computing word width from `NBYTES`.
- Single module. The shift register, byte counter and idle counter are inline; no sub-module is warranted.

## Test plan
- Reset, then bytes 0x12,0x55,0x66,0x78,0x90 on 5 consecutive edges (`GAP`=4, `NBYTES`=5) -> one `ready` pulse after edge 5, `dout`=0x1255667890, `busy` low afterwards, `error` never asserted.
- Same bytes with 3 idle cycles between each -> identical `dout`, `ready` once, no `error`.
- Bytes 0xAA,0xBB, then 4 idle cycles -> `error` pulse after the 4th idle edge and `dout` remains 0x1255667890. Then 0x01..0x05 -> `dout`=0x0102030405.
- Two words back-to-back (0x0102030405 then 0xF1F2F3F4F5, 10 consecutive bytes) -> `ready` after edges 5 and 10 with the correct words, never merged or shifted.
- `rst` asserted after the 3rd byte of a word -> all outputs 0. The following 5 bytes form a clean word with no residue of the pre-reset bytes.
- Loopback: `data8out` #(4,5) loaded with 0x1255667890 drives this block -> exactly one `ready` with `dout`=0x1255667890 within 30 cycles.

Source files
------------

// File: rtl/data8_pkg.sv
// Shared definitions for the data8out / data8in byte-stream pair.
// Holds the byte width, state encoding and word-width helper.
package data8_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  function automatic int word_w(input int nbytes);
    return BYTE_W * nbytes;
  endfunction

endpackage

// File: rtl/data8in.sv
// Byte-to-word deserializer: assembles NBYTES bytes (MSB first) into one word,
// pulses ready on completion and error when a partial word stalls past GAP idle cycles.
module data8in
  import data8_pkg::*;
#(
  parameter int GAP    = 4,
  parameter int NBYTES = 5
) (
  input  logic                        pclk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           din,
  input  logic                        inputReady,
  output logic [word_w(NBYTES)-1:0]   dout,
  output logic                        ready,
  output logic                        busy,
  output logic                        error
);

  localparam int WW    = word_w(NBYTES);
  localparam int CNT_W = $clog2(NBYTES + 1);
  // A zero GAP still needs a one-bit counter so the declarations stay legal.
  localparam int IDL_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES);
  localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(GAP);
  localparam logic [IDL_W-1:0] IDL_MAX  = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDL_W-1:0]  idle;
  logic [WW-1:0]     shreg_p0;
  logic [WW-1:0]     shifted;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDL_W-1:0]  idle_inc;

  // Concatenate then truncate so NBYTES=1 needs no special-case slice.
  function automatic logic [WW-1:0] shift_in(input logic [WW-1:0] sr,
                                             input logic [BYTE_W-1:0] b);
    logic [WW+BYTE_W-1:0] t;
    t = {sr, b};
    return t[WW-1:0];
  endfunction

  function automatic logic [IDL_W-1:0] sat_inc(input logic [IDL_W-1:0] v);
    return (v == IDL_MAX) ? v : v + IDL_W'(1);
  endfunction

  assign shifted  = shift_in(shreg_p0, din);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign idle_inc = sat_inc(idle);

  // Stage p0: byte capture. Stale bytes shift out before any word completes,
  // so the shift register needs no reset.
  always_ff @(posedge pclk) begin
    if (inputReady) begin
      shreg_p0 <= shifted;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idle  <= '0;
      dout  <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      if (inputReady) begin
        // An arriving byte always wins over a pending timeout.
        idle <= '0;
        if (cnt_inc == CNT_LAST) begin
          dout  <= shifted;
          ready <= 1'b1;
          cnt   <= '0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt   <= cnt_inc;
          state <= ST_COLLECT;
          busy  <= 1'b1;
        end
      end else if (state == ST_COLLECT && GAP > 0) begin
        if (idle_inc == IDL_LAST) begin
          error <= 1'b1;
          cnt   <= '0;
          idle  <= '0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          idle <= idle_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_data8in.sv
// Directed self-checking bench for data8in with GAP=4, NBYTES=5.
module tb_data8in;
  import data8_pkg::*;

  logic        pclk;
  logic        rst;
  logic [7:0]  din;
  logic        inputReady;
  logic [39:0] dout;
  logic        ready;
  logic        busy;
  logic        error;

  int n_cmp;
  int n_bad;

  localparam logic [39:0] W1 = 40'h1255667890;
  localparam logic [39:0] W2 = 40'h0102030405;
  localparam logic [39:0] W3 = 40'hF1F2F3F4F5;

  data8in #(.GAP(4), .NBYTES(5)) dut (
    .pclk(pclk), .rst(rst), .din(din), .inputReady(inputReady),
    .dout(dout), .ready(ready), .busy(busy), .error(error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One clock: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] b);
    @(negedge pclk);
    rst = r; inputReady = v; din = b;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hEE);
    n_cmp++; if (dout !== 40'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_single_word();
    logic [7:0] b [5] = '{8'h12, 8'h55, 8'h66, 8'h78, 8'h90};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, b[i]);
      if (i < 4) begin
        n_cmp++; if (ready !== 1'b0 || busy !== 1'b1) begin n_bad++;
          $display("FAIL single_mid%0d: got ready=%b busy=%b want ready=0 busy=1", i, ready, busy); end
      end
    end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", ready); end
    n_cmp++; if (dout !== W1) begin n_bad++; $display("FAIL single_dout: got %h want %h", dout, W1); end
    n_cmp++; if (busy !== 1'b0 || error !== 1'b0) begin n_bad++;
      $display("FAIL single_flags: got busy=%b error=%b want 0 0", busy, error); end
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++; if (ready !== 1'b0 || dout !== W1) begin n_bad++;
      $display("FAIL single_hold: got ready=%b dout=%h want 0 %h", ready, dout, W1); end
  endtask

  task automatic test_gapped();
    logic [7:0] b [5] = '{8'h12, 8'h55, 8'h66, 8'h78, 8'h90};
    int nrdy = 0;
    int nerr = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, b[i]);
      nrdy += int'(ready); nerr += int'(error);
      if (i < 4) begin
        for (int k = 0; k < 3; k++) begin
          cyc(1'b0, 1'b0, 8'h00);
          nrdy += int'(ready); nerr += int'(error);
        end
      end
    end
    n_cmp++; if (dout !== W1) begin n_bad++; $display("FAIL gapped_dout: got %h want %h", dout, W1); end
    n_cmp++; if (nrdy !== 1) begin n_bad++; $display("FAIL gapped_ready_count: got %0d want 1", nrdy); end
    n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL gapped_error_count: got %0d want 0", nerr); end
  endtask

  task automatic test_timeout();
    cyc(1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b1, 8'hBB);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00);
      if (k < 4) begin
        n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++;
          $display("FAIL timeout_idle%0d: got error=%b busy=%b want 0 1", k, error, busy); end
      end
    end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL timeout_error: got %b want 1", error); end
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_bad++;
      $display("FAIL timeout_flags: got busy=%b ready=%b want 0 0", busy, ready); end
    n_cmp++; if (dout !== W1) begin n_bad++; $display("FAIL timeout_dout_kept: got %h want %h", dout, W1); end
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: got %b want 0", error); end
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 8'(i));
    n_cmp++; if (ready !== 1'b1 || dout !== W2) begin n_bad++;
      $display("FAIL timeout_realign: got ready=%b dout=%h want 1 %h", ready, dout, W2); end
  endtask

  task automatic test_accept_at_gap();
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b1, 8'h22);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h33);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL gap_edge_accept: got error=%b busy=%b want 0 1", error, busy); end
    cyc(1'b0, 1'b1, 8'h44);
    cyc(1'b0, 1'b1, 8'h55);
    n_cmp++; if (ready !== 1'b1 || dout !== 40'h1122334455) begin n_bad++;
      $display("FAIL gap_edge_word: got ready=%b dout=%h want 1 1122334455", ready, dout); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                           8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, b[i]);
      if (i == 4) begin
        n_cmp++; if (ready !== 1'b1 || dout !== W2) begin n_bad++;
          $display("FAIL b2b_word1: got ready=%b dout=%h want 1 %h", ready, dout, W2); end
      end else if (i == 5) begin
        n_cmp++; if (ready !== 1'b0 || busy !== 1'b1 || dout !== W2) begin n_bad++;
          $display("FAIL b2b_next_start: got ready=%b busy=%b dout=%h want 0 1 %h", ready, busy, dout, W2); end
      end else if (i == 9) begin
        n_cmp++; if (ready !== 1'b1 || dout !== W3) begin n_bad++;
          $display("FAIL b2b_word2: got ready=%b dout=%h want 1 %h", ready, dout, W3); end
      end
      n_cmp++; if (ready === 1'b1 && error === 1'b1) begin n_bad++;
        $display("FAIL b2b_exclusive: got ready=1 error=1 want not both"); end
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b0, 1'b1, 8'hC1);
    cyc(1'b0, 1'b1, 8'hC2);
    cyc(1'b0, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'hEE);
    n_cmp++; if (dout !== 40'h0 || ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin n_bad++;
      $display("FAIL midrst_outputs: got dout=%h ready=%b busy=%b error=%b want all 0", dout, ready, busy, error); end
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'hA1 + 8'(i));
    n_cmp++; if (ready !== 1'b1 || dout !== 40'hA1A2A3A4A5) begin n_bad++;
      $display("FAIL midrst_clean_word: got ready=%b dout=%h want 1 a1a2a3a4a5", ready, dout); end
  endtask

  // Stand-in for data8out: serializes a word MSB first, one byte every other cycle.
  task automatic test_loopback();
    logic [39:0] w = W1;
    logic [39:0] cap = '0;
    int idx = 0;
    int nrdy = 0;
    int nerr = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 5 && (c % 2) == 0) begin
        cyc(1'b0, 1'b1, w[39 - 8*idx -: 8]);
        idx++;
      end else begin
        cyc(1'b0, 1'b0, 8'h00);
      end
      if (ready === 1'b1) begin nrdy++; cap = dout; end
      nerr += int'(error);
    end
    n_cmp++; if (nrdy !== 1) begin n_bad++; $display("FAIL loopback_ready_count: got %0d want 1", nrdy); end
    n_cmp++; if (cap !== W1) begin n_bad++; $display("FAIL loopback_dout: got %h want %h", cap, W1); end
    n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL loopback_error: got %0d want 0", nerr); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    inputReady = 1'b0;
    din = 8'h00;
    test_reset();
    test_single_word();
    test_gapped();
    test_timeout();
    test_accept_at_gap();
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
